// File: rtl/vga_timing_gen.sv
// Raster timing generator: mode shadowing, h/v counters, source strobes and aligned video out.
// Latency: counters -> o_rd 1 clk, o_rd -> o_pixel/o_de/syncs 1 clk; no backpressure (source must keep up).
module vga_timing_gen #(
    parameter int HW  = 12,
    parameter int VW  = 12,
    parameter int BPP = 12
) (
    input  logic           i_pixclk,
    input  logic           i_reset_n,
    input  logic [HW-1:0]  i_hm_width,
    input  logic [HW-1:0]  i_hm_porch,
    input  logic [HW-1:0]  i_hm_synch,
    input  logic [HW-1:0]  i_hm_raw,
    input  logic [VW-1:0]  i_vm_height,
    input  logic [VW-1:0]  i_vm_porch,
    input  logic [VW-1:0]  i_vm_synch,
    input  logic [VW-1:0]  i_vm_raw,
    input  logic           i_hpol,
    input  logic           i_vpol,
    input  logic [BPP-1:0] i_pixel,
    output logic           o_rd,
    output logic           o_newline,
    output logic           o_newframe,
    output logic [BPP-1:0] o_pixel,
    output logic           o_de,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_err
);

    localparam logic [HW-1:0] H_ONE = HW'(1);
    localparam logic [VW-1:0] V_ONE = VW'(1);

    logic [HW-1:0]  hm_width_q, hm_width_d, hm_porch_q, hm_porch_d;
    logic [HW-1:0]  hm_synch_q, hm_synch_d, hm_raw_q, hm_raw_d;
    logic [VW-1:0]  vm_height_q, vm_height_d, vm_porch_q, vm_porch_d;
    logic [VW-1:0]  vm_synch_q, vm_synch_d, vm_raw_q, vm_raw_d;
    logic           hpol_q, hpol_d, vpol_q, vpol_d;
    logic           load_pending_q, load_pending_d, err_q, err_d;
    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic           rd_q, rd_d, newline_q, newline_d, newframe_q, newframe_d;
    logic           hs1_q, hs1_d, vs1_q, vs1_d;
    logic           de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [BPP-1:0] pixel_q, pixel_d;

    logic mode_ok, run, h_last, v_last, load;

    always_comb begin
        mode_ok = (i_hm_width != '0) && (i_hm_width <= i_hm_porch) &&
                  (i_hm_porch <= i_hm_synch) && (i_hm_synch < i_hm_raw) &&
                  (i_vm_height != '0) && (i_vm_height <= i_vm_porch) &&
                  (i_vm_porch <= i_vm_synch) && (i_vm_synch < i_vm_raw);
        // Counting only runs once a valid mode sits in the shadow registers.
        run    = !load_pending_q;
        h_last = (h_q == hm_raw_q - H_ONE);
        v_last = (v_q == vm_raw_q - V_ONE);
        load   = load_pending_q || (run && h_last && v_last);

        hm_width_d     = hm_width_q;
        hm_porch_d     = hm_porch_q;
        hm_synch_d     = hm_synch_q;
        hm_raw_d       = hm_raw_q;
        vm_height_d    = vm_height_q;
        vm_porch_d     = vm_porch_q;
        vm_synch_d     = vm_synch_q;
        vm_raw_d       = vm_raw_q;
        hpol_d         = hpol_q;
        vpol_d         = vpol_q;
        load_pending_d = load_pending_q;
        err_d          = err_q;
        if (load) begin
            hm_width_d     = i_hm_width;
            hm_porch_d     = i_hm_porch;
            hm_synch_d     = i_hm_synch;
            hm_raw_d       = i_hm_raw;
            vm_height_d    = i_vm_height;
            vm_porch_d     = i_vm_porch;
            vm_synch_d     = i_vm_synch;
            vm_raw_d       = i_vm_raw;
            hpol_d         = i_hpol;
            vpol_d         = i_vpol;
            load_pending_d = !mode_ok;
            err_d          = !mode_ok;
        end

        h_d = '0;
        v_d = '0;
        if (run) begin
            if (h_last) begin
                v_d = v_last ? '0 : v_q + V_ONE;
            end else begin
                h_d = h_q + H_ONE;
                v_d = v_q;
            end
        end

        rd_d       = run && (h_q < hm_width_q) && (v_q < vm_height_q);
        newline_d  = run && h_last;
        newframe_d = run && h_last && v_last;
        hs1_d      = run && (h_q >= hm_porch_q) && (h_q < hm_synch_q);
        vs1_d      = run && (v_q >= vm_porch_q) && (v_q < vm_synch_q);

        // Pixel, enable and syncs share this stage so they leave aligned.
        de_d    = rd_q;
        pixel_d = rd_q ? i_pixel : '0;
        hsync_d = ~(hs1_q ^ hpol_q);
        vsync_d = ~(vs1_q ^ vpol_q);
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hm_width_q     <= '0;
            hm_porch_q     <= '0;
            hm_synch_q     <= '0;
            hm_raw_q       <= '0;
            vm_height_q    <= '0;
            vm_porch_q     <= '0;
            vm_synch_q     <= '0;
            vm_raw_q       <= '0;
            hpol_q         <= 1'b0;
            vpol_q         <= 1'b0;
            load_pending_q <= 1'b1;
            err_q          <= 1'b0;
            h_q            <= '0;
            v_q            <= '0;
            rd_q           <= 1'b0;
            newline_q      <= 1'b0;
            newframe_q     <= 1'b0;
            hs1_q          <= 1'b0;
            vs1_q          <= 1'b0;
            de_q           <= 1'b0;
            pixel_q        <= '0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
        end else begin
            hm_width_q     <= hm_width_d;
            hm_porch_q     <= hm_porch_d;
            hm_synch_q     <= hm_synch_d;
            hm_raw_q       <= hm_raw_d;
            vm_height_q    <= vm_height_d;
            vm_porch_q     <= vm_porch_d;
            vm_synch_q     <= vm_synch_d;
            vm_raw_q       <= vm_raw_d;
            hpol_q         <= hpol_d;
            vpol_q         <= vpol_d;
            load_pending_q <= load_pending_d;
            err_q          <= err_d;
            h_q            <= h_d;
            v_q            <= v_d;
            rd_q           <= rd_d;
            newline_q      <= newline_d;
            newframe_q     <= newframe_d;
            hs1_q          <= hs1_d;
            vs1_q          <= vs1_d;
            de_q           <= de_d;
            pixel_q        <= pixel_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
        end
    end

    assign o_rd       = rd_q;
    assign o_newline  = newline_q;
    assign o_newframe = newframe_q;
    assign o_pixel    = pixel_q;
    assign o_de       = de_q;
    assign o_hsync    = hsync_q;
    assign o_vsync    = vsync_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small mode, mode change, invalid mode, async reset, 640x480 line.
module tb_vga_timing_gen;

    logic        i_pixclk;
    logic        i_reset_n;
    logic [11:0] i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw;
    logic [11:0] i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw;
    logic        i_hpol, i_vpol;
    logic [11:0] i_pixel;
    logic        o_rd, o_newline, o_newframe, o_de, o_hsync, o_vsync, o_err;
    logic [11:0] o_pixel;

    vga_timing_gen #(.HW(12), .VW(12), .BPP(12)) dut (
        .i_pixclk   (i_pixclk),
        .i_reset_n  (i_reset_n),
        .i_hm_width (i_hm_width),
        .i_hm_porch (i_hm_porch),
        .i_hm_synch (i_hm_synch),
        .i_hm_raw   (i_hm_raw),
        .i_vm_height(i_vm_height),
        .i_vm_porch (i_vm_porch),
        .i_vm_synch (i_vm_synch),
        .i_vm_raw   (i_vm_raw),
        .i_hpol     (i_hpol),
        .i_vpol     (i_vpol),
        .i_pixel    (i_pixel),
        .o_rd       (o_rd),
        .o_newline  (o_newline),
        .o_newframe (o_newframe),
        .o_pixel    (o_pixel),
        .o_de       (o_de),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_err      (o_err)
    );

    initial begin
        i_pixclk = 1'b0;
        forever #5 i_pixclk = ~i_pixclk;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rd, n_nl, n_nf, n_de, n_hs0, n_vs0, n_badblank;
    logic [11:0] pix_seq = 12'd0;
    logic [11:0] exp_pix = 12'd0;
    int          n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_rd = 0; n_nl = 0; n_nf = 0; n_de = 0; n_hs0 = 0; n_vs0 = 0; n_badblank = 0;
    endtask

    // One clock: sample outputs at the falling edge, then act as the pixel source.
    task automatic tick();
        @(negedge i_pixclk);
        if (o_rd)       n_rd++;
        if (o_newline)  n_nl++;
        if (o_newframe) n_nf++;
        if (!o_hsync)   n_hs0++;
        if (!o_vsync)   n_vs0++;
        if (o_de) begin
            n_de++;
            check("pixel", o_pixel, exp_pix);
            exp_pix = exp_pix + 12'd1;
        end else if (o_pixel != 12'd0) begin
            n_badblank++;
        end
        if (o_rd) begin
            i_pixel = pix_seq;
            pix_seq = pix_seq + 12'd1;
        end else begin
            i_pixel = 12'hABC;
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return o_rd;
            1:       return o_newline;
            2:       return o_hsync;
            3:       return o_err;
            default: return o_newframe;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic lvl, input int limit, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (sel(which) !== lvl && cnt < limit);
        if (sel(which) !== lvl) check("wait_timeout", 32'(sel(which)), 32'(lvl));
    endtask

    task automatic run(input int cycles);
        repeat (cycles) tick();
    endtask

    task automatic set_mode(input int w, input int p, input int s, input int r,
                            input int h, input int vp, input int vs, input int vr);
        i_hm_width  = 12'(w);  i_hm_porch = 12'(p);  i_hm_synch = 12'(s);  i_hm_raw = 12'(r);
        i_vm_height = 12'(h);  i_vm_porch = 12'(vp); i_vm_synch = 12'(vs); i_vm_raw = 12'(vr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset_n = 1'b0;
        i_pixel   = 12'd0;
        i_hpol    = 1'b0;
        i_vpol    = 1'b0;
        set_mode(4, 5, 6, 8, 2, 3, 4, 5);
        clear_counts();
        run(3);
        check("rst_rd", o_rd, 0);
        check("rst_newline", o_newline, 0);
        check("rst_newframe", o_newframe, 0);
        check("rst_de", o_de, 0);
        check("rst_err", o_err, 0);
        check("rst_pixel", o_pixel, 0);
        check("rst_hsync", o_hsync, 0);
        check("rst_vsync", o_vsync, 0);

        // Cold start: mode load on clock 1, first request on clock 2.
        i_reset_n = 1'b1;
        tick();
        check("cold_rd_clk1", o_rd, 0);
        tick();
        check("cold_rd_clk2", o_rd, 1);
        check("cold_err", o_err, 0);

        clear_counts();
        run(40);
        check("frame_rd", n_rd, 8);
        check("frame_newline", n_nl, 5);
        check("frame_newframe", n_nf, 1);
        check("frame_hsync_low", n_hs0, 5);
        check("frame_vsync_low", n_vs0, 8);
        check("frame_de", n_de, 8);
        check("frame_blank_pixel", n_badblank, 0);

        wait_sig(1, 1'b1, 20, n);
        wait_sig(0, 1'b1, 20, n);
        check("line1_rd_after_nl", n, 1);
        wait_sig(2, 1'b0, 20, n);
        check("hsync_after_rd", n, 6);
        wait_sig(1, 1'b1, 20, n);
        wait_sig(1, 1'b1, 20, n);
        check("newline_period", n, 8);
        wait_sig(4, 1'b1, 60, n);
        wait_sig(4, 1'b1, 60, n);
        check("newframe_period", n, 40);

        // Width 4 -> 3 in the middle of line 1: this frame keeps width 4.
        run(10);
        i_hm_width = 12'd3;
        clear_counts();
        wait_sig(4, 1'b1, 60, n);
        check("midframe_rd_rest", n_rd, 2);
        clear_counts();
        run(40);
        check("nextframe_rd", n_rd, 6);
        check("nextframe_newline", n_nl, 5);

        // Invalid mode (porch < width) takes hold at the next frame end.
        i_hm_porch = 12'd2;
        wait_sig(3, 1'b1, 60, n);
        check("err_rise_delay", n, 40);
        clear_counts();
        run(20);
        check("err_held", o_err, 1);
        check("err_rd", n_rd, 0);
        check("err_newline", n_nl, 0);
        check("err_newframe", n_nf, 0);
        check("err_de", n_de, 0);
        check("err_hsync_low", n_hs0, 0);
        check("err_vsync_low", n_vs0, 0);
        check("err_blank_pixel", n_badblank, 0);

        i_hm_porch = 12'd5;
        wait_sig(3, 1'b0, 5, n);
        check("err_fall_delay", n, 1);
        wait_sig(1, 1'b1, 20, n);
        check("first_newline_after_err", n, 8);

        // Async reset while a line is active.
        wait_sig(0, 1'b1, 20, n);
        tick();
        #2;
        i_reset_n = 1'b0;
        #1;
        check("async_rd", o_rd, 0);
        check("async_de", o_de, 0);
        check("async_pixel", o_pixel, 0);
        check("async_hsync", o_hsync, 0);
        check("async_newline", o_newline, 0);
        exp_pix = pix_seq;
        #1;
        i_reset_n = 1'b1;
        tick();
        check("restart_rd_clk1", o_rd, 0);
        tick();
        check("restart_rd_clk2", o_rd, 1);
        clear_counts();
        run(40);
        check("restart_rd", n_rd, 6);
        check("restart_newline", n_nl, 5);
        check("restart_newframe", n_nf, 1);
        check("restart_hsync_low", n_hs0, 5);
        check("restart_vsync_low", n_vs0, 8);
        check("restart_de", n_de, 6);

        // 640x480 timing: one frame end to switch, then line-level checks.
        set_mode(640, 656, 752, 800, 480, 490, 492, 525);
        wait_sig(4, 1'b1, 60, n);
        wait_sig(1, 1'b1, 1000, n);
        check("vga_line_period", n, 800);
        clear_counts();
        run(800);
        check("vga_rd", n_rd, 640);
        check("vga_de", n_de, 640);
        check("vga_hsync_low", n_hs0, 96);
        check("vga_newline", n_nl, 1);
        check("vga_vsync_low", n_vs0, 0);
        check("vga_blank_pixel", n_badblank, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
